// File: rtl/musa_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : musa_mem_pkg
//  Description : Shared definitions for the load/store controller in front of
//                the MEM_WB data RAM: access-size encodings, controller state
//                enum and byte-lane helper functions.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package musa_mem_pkg;

    // req_size encodings
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_WAIT = 3'd2,
        ST_WR   = 3'd3,
        ST_RESP = 3'd4
    } state_e;

    // Bit position of the selected lane inside the 32-bit word (little-endian).
    function automatic logic [4:0] lane_shift(input logic [1:0] offset,
                                              input logic [1:0] size);
        case (size)
            SZ_BYTE: lane_shift = {offset, 3'b000};
            SZ_HALF: lane_shift = {offset[1], 4'b0000};
            default: lane_shift = 5'd0;
        endcase
    endfunction

    // Right-justified mask covering one lane of the given size.
    function automatic logic [31:0] lane_mask(input logic [1:0] size);
        case (size)
            SZ_BYTE: lane_mask = 32'h0000_00FF;
            SZ_HALF: lane_mask = 32'h0000_FFFF;
            default: lane_mask = 32'hFFFF_FFFF;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_lane_align.sv
`default_nettype none
// ============================================================================
//  Module      : mem_lane_align
//  Description : Combinational byte-lane alignment. Extracts (and optionally
//                sign-extends) the addressed lane of a RAM word for loads, and
//                merges store data into the addressed lane for sub-word stores.
//  Ports       : i_word       - 32-bit word read from RAM
//                i_offset     - byte offset within the word (addr[1:0])
//                i_size       - access size encoding
//                i_is_signed  - sign-extend sub-word loads
//                i_wdata      - right-justified store data
//                o_load_data  - extracted load result
//                o_store_word - i_word with the addressed lane replaced
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_lane_align
    import musa_mem_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_offset,
    input  logic [1:0]  i_size,
    input  logic        i_is_signed,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_load_data,
    output logic [31:0] o_store_word
);

    logic [4:0]  w_shamt;
    logic [31:0] w_mask;
    logic [31:0] w_lane;
    logic [31:0] w_place_mask;
    logic        w_sign_bit;

    always_comb begin
        w_shamt      = lane_shift(i_offset, i_size);
        w_mask       = lane_mask(i_size);
        w_lane       = (i_word >> w_shamt) & w_mask;
        w_sign_bit   = (i_size == SZ_BYTE) ? w_lane[7] : w_lane[15];

        o_load_data  = w_lane;
        // Full words carry no extension bits (~w_mask is zero), so the size
        // test only keeps the intent obvious.
        if (i_is_signed && (i_size != SZ_WORD) && w_sign_bit) begin
            o_load_data = w_lane | ~w_mask;
        end

        w_place_mask = w_mask << w_shamt;
        o_store_word = (i_word & ~w_place_mask) | ((i_wdata << w_shamt) & w_place_mask);
    end

endmodule
`default_nettype wire

// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_ctrl
//  Description : Load/store controller between the EX/MEM pipeline register
//                and the word-addressed MEM_WB data RAM. Validates requests,
//                issues RAM reads/writes, performs read-modify-write for
//                sub-word stores and returns aligned load data with its tag.
//  Ports       : clk, rst_n               - clock, async active-low reset
//                req_*                    - byte-addressed request from core
//                busy                     - stall to core (state != IDLE)
//                wb_valid/wb_data/wb_rd   - load writeback
//                done/err                 - completion / error pulses
//                mem_*                    - RAM nd/rdy/we/addr/din/dout port
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_access_ctrl
    import musa_mem_pkg::*;
#(
    parameter int ADDR_W  = 11,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [4:0]        req_rd,
    output logic              busy,
    output logic              wb_valid,
    output logic [31:0]       wb_data,
    output logic [4:0]        wb_rd,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_din,
    input  logic [31:0]       mem_dout,
    output logic              mem_nd,
    input  logic              mem_rdy,
    output logic              mem_we
);

    localparam logic [7:0] C_TIMEOUT = 8'(TIMEOUT);

    state_e              state_q,    state_d;
    logic                we_q,       we_d;
    logic [1:0]          size_q,     size_d;
    logic                signed_q,   signed_d;
    logic [ADDR_W+1:0]   addr_q,     addr_d;
    logic [31:0]         wdata_q,    wdata_d;
    logic [4:0]          rd_q,       rd_d;
    logic [7:0]          cnt_q,      cnt_d;
    logic                wb_valid_q, wb_valid_d;
    logic [31:0]         wb_data_q,  wb_data_d;
    logic [4:0]          wb_rd_q,    wb_rd_d;
    logic                done_q,     done_d;
    logic                err_q,      err_d;
    logic                mem_nd_q,   mem_nd_d;
    logic                mem_we_q,   mem_we_d;
    logic [31:0]         mem_din_q,  mem_din_d;

    logic                w_misaligned;
    logic                w_out_of_range;
    logic                w_bad_req;
    logic [7:0]          w_cnt_inc;
    logic [31:0]         w_load_data;
    logic [31:0]         w_store_word;

    // Alignment always works on the latched request and the live RAM output;
    // its results are only consumed in WAIT when mem_rdy is high.
    mem_lane_align u_align (
        .i_word       (mem_dout),
        .i_offset     (addr_q[1:0]),
        .i_size       (size_q),
        .i_is_signed  (signed_q),
        .i_wdata      (wdata_q),
        .o_load_data  (w_load_data),
        .o_store_word (w_store_word)
    );

    always_comb begin
        w_misaligned   = ((req_size == SZ_HALF) && req_addr[0]) ||
                         ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
        w_out_of_range = (req_addr[31:ADDR_W+2] != '0);
        w_bad_req      = (req_size == SZ_ILL) || w_misaligned || w_out_of_range;
        w_cnt_inc      = cnt_q + 8'd1;
    end

    always_comb begin
        // Hold registers by default; strobes default low so they pulse once.
        state_d    = state_q;
        we_d       = we_q;
        size_d     = size_q;
        signed_d   = signed_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rd_d       = rd_q;
        cnt_d      = cnt_q;
        wb_data_d  = wb_data_q;
        wb_rd_d    = wb_rd_q;
        mem_din_d  = mem_din_q;
        wb_valid_d = 1'b0;
        done_d     = 1'b0;
        err_d      = 1'b0;
        mem_nd_d   = 1'b0;
        mem_we_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    we_d     = req_we;
                    size_d   = req_size;
                    signed_d = req_signed;
                    addr_d   = req_addr[ADDR_W+1:0];
                    wdata_d  = req_wdata;
                    rd_d     = req_rd;
                    if (w_bad_req) begin
                        err_d  = 1'b1;
                        done_d = 1'b1;
                    end else if (req_we && (req_size == SZ_WORD)) begin
                        // Full-word stores need no read, go straight to write.
                        mem_din_d = req_wdata;
                        mem_we_d  = 1'b1;
                        state_d   = ST_WR;
                    end else begin
                        mem_nd_d  = 1'b1;
                        state_d   = ST_RD;
                    end
                end
            end

            ST_RD: begin
                cnt_d   = 8'd0;
                state_d = ST_WAIT;
            end

            ST_WAIT: begin
                if (mem_rdy) begin
                    if (we_q) begin
                        mem_din_d = w_store_word;
                        mem_we_d  = 1'b1;
                        state_d   = ST_WR;
                    end else begin
                        wb_data_d  = w_load_data;
                        wb_rd_d    = rd_q;
                        wb_valid_d = 1'b1;
                        done_d     = 1'b1;
                        state_d    = ST_RESP;
                    end
                end else begin
                    cnt_d = w_cnt_inc;
                    if (w_cnt_inc == C_TIMEOUT) begin
                        err_d   = 1'b1;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end

            ST_WR: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end

            ST_RESP: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            we_q       <= 1'b0;
            size_q     <= 2'b00;
            signed_q   <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= 32'd0;
            rd_q       <= 5'd0;
            cnt_q      <= 8'd0;
            wb_valid_q <= 1'b0;
            wb_data_q  <= 32'd0;
            wb_rd_q    <= 5'd0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            mem_nd_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_din_q  <= 32'd0;
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            size_q     <= size_d;
            signed_q   <= signed_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rd_q       <= rd_d;
            cnt_q      <= cnt_d;
            wb_valid_q <= wb_valid_d;
            wb_data_q  <= wb_data_d;
            wb_rd_q    <= wb_rd_d;
            done_q     <= done_d;
            err_q      <= err_d;
            mem_nd_q   <= mem_nd_d;
            mem_we_q   <= mem_we_d;
            mem_din_q  <= mem_din_d;
        end
    end

    assign busy     = (state_q != ST_IDLE);
    assign wb_valid = wb_valid_q;
    assign wb_data  = wb_data_q;
    assign wb_rd    = wb_rd_q;
    assign done     = done_q;
    assign err      = err_q;
    assign mem_addr = addr_q[ADDR_W+1:2];
    assign mem_din  = mem_din_q;
    assign mem_nd   = mem_nd_q;
    assign mem_we   = mem_we_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_access_ctrl
//  Description : Self-checking bench for mem_access_ctrl with a behavioural
//                RAM (optional read latency / never-ready) and a word-array
//                reference model of memory contents and load results.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_ctrl;

    localparam int ADDR_W  = 11;
    localparam int TIMEOUT = 15;
    localparam int DEPTH   = 1 << ADDR_W;

    logic              clk;
    logic              rst_n;
    logic              req_valid, req_we, req_signed;
    logic [1:0]        req_size;
    logic [31:0]       req_addr, req_wdata;
    logic [4:0]        req_rd;
    logic              busy, wb_valid, done, err;
    logic [31:0]       wb_data;
    logic [4:0]        wb_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_din, mem_dout;
    logic              mem_nd, mem_rdy, mem_we;

    mem_access_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_we(req_we), .req_size(req_size),
        .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_rd(req_rd), .busy(busy), .wb_valid(wb_valid), .wb_data(wb_data),
        .wb_rd(wb_rd), .done(done), .err(err), .mem_addr(mem_addr),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_nd(mem_nd),
        .mem_rdy(mem_rdy), .mem_we(mem_we)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural RAM ----------------
    logic [31:0]       ram     [DEPTH];
    logic [31:0]       ref_mem [DEPTH];
    logic              ram_init, rdy_block;
    int                ram_delay, pend;
    logic [ADDR_W-1:0] paddr;

    function automatic logic [31:0] init_pat(input int i);
        return (32'(i) * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
    endfunction

    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < DEPTH; i++) ram[i] <= init_pat(i);
            pend <= 0;
        end else if (mem_we) begin
            ram[mem_addr] <= mem_din;
        end
        mem_rdy  <= 1'b0;
        mem_dout <= 32'd0;
        if (!ram_init && mem_nd && !rdy_block) begin
            if (ram_delay == 0) begin
                mem_rdy  <= 1'b1;
                mem_dout <= ram[mem_addr];
            end else begin
                pend  <= ram_delay;
                paddr <= mem_addr;
            end
        end else if (!ram_init && pend != 0 && !rdy_block) begin
            pend <= pend - 1;
            if (pend == 1) begin
                mem_rdy  <= 1'b1;
                mem_dout <= ram[paddr];
            end
        end
    end

    // ---------------- checking helpers ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // Reference model: error decision and expected load value / new word.
    function automatic void model(input logic we, input logic [1:0] size, input logic sgn,
                                  input logic [31:0] addr, input logic [31:0] wdata,
                                  output logic e, output logic [31:0] v);
        logic [31:0] w;
        logic [7:0]  b;
        logic [15:0] h;
        int          off;
        e   = (size == 2'd3) || (size == 2'd1 && addr[0]) ||
              (size == 2'd2 && addr[1:0] != 2'd0) || (addr[31:ADDR_W+2] != '0);
        w   = ref_mem[addr[ADDR_W+1:2]];
        off = int'(addr[1:0]);
        b   = w[8*off +: 8];
        h   = w[16*(off/2) +: 16];
        v   = w;
        if (!we) begin
            case (size)
                2'd0:    v = sgn ? {{24{b[7]}}, b}  : {24'd0, b};
                2'd1:    v = sgn ? {{16{h[15]}}, h} : {16'd0, h};
                default: v = w;
            endcase
        end else begin
            case (size)
                2'd0:    v[8*off +: 8]       = wdata[7:0];
                2'd1:    v[16*(off/2) +: 16] = wdata[15:0];
                default: v = wdata;
            endcase
        end
    endfunction

    int                m_done_c, m_done_n, m_err_n, m_nd_n, m_nd_c, m_we_n, m_we_c;
    int                m_wbv_n, m_wbv_c, m_busy_n;
    logic [31:0]       m_we_din, m_wb_data;
    logic [ADDR_W-1:0] m_we_addr, m_nd_addr;
    logic [4:0]        m_wb_rd;

    task automatic issue(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd);
        @(negedge clk);
        req_we = we; req_size = size; req_signed = sgn;
        req_addr = addr; req_wdata = wdata; req_rd = rd; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    // Samples cycles 1..maxc after the request edge; stops one cycle after done.
    task automatic monitor(input int maxc);
        m_done_c = 0; m_done_n = 0; m_err_n = 0; m_nd_n = 0; m_nd_c = 0;
        m_we_n = 0; m_we_c = 0; m_wbv_n = 0; m_wbv_c = 0; m_busy_n = 0;
        m_we_din = 32'd0; m_wb_data = 32'd0; m_we_addr = '0; m_nd_addr = '0; m_wb_rd = 5'd0;
        for (int k = 1; k <= maxc; k++) begin
            @(negedge clk);
            if (busy) m_busy_n++;
            if (mem_nd) begin m_nd_n++; m_nd_c = k; m_nd_addr = mem_addr; end
            if (mem_we) begin m_we_n++; m_we_c = k; m_we_din = mem_din; m_we_addr = mem_addr; end
            if (wb_valid) begin m_wbv_n++; m_wbv_c = k; m_wb_data = wb_data; m_wb_rd = wb_rd; end
            if (err) m_err_n++;
            if (done) begin
                m_done_n++;
                if (m_done_c == 0) m_done_c = k;
            end
            if (m_done_c != 0 && k > m_done_c) break;
        end
    endtask

    task automatic run_txn(input string tag, input logic we, input logic [1:0] size,
                           input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [4:0] rd, input logic exp_err, input logic [31:0] exp_val);
        int d, e_done, e_busy;
        logic [ADDR_W-1:0] widx;
        d    = ram_delay;
        widx = addr[ADDR_W+1:2];
        if (exp_err)              begin e_done = 1;     e_busy = 0;     end
        else if (!we)             begin e_done = 3 + d; e_busy = 3 + d; end
        else if (size == 2'd2)    begin e_done = 2;     e_busy = 1;     end
        else                      begin e_done = 4 + d; e_busy = 3 + d; end
        issue(we, size, sgn, addr, wdata, rd);
        monitor(40);
        check({tag, " done_cycle"}, 32'(m_done_c), 32'(e_done));
        check({tag, " done_count"}, 32'(m_done_n), 32'd1);
        check({tag, " err_count"},  32'(m_err_n),  exp_err ? 32'd1 : 32'd0);
        check({tag, " busy_cycles"}, 32'(m_busy_n), 32'(e_busy));
        check({tag, " nd_count"}, 32'(m_nd_n),
              (!exp_err && !(we && size == 2'd2)) ? 32'd1 : 32'd0);
        check({tag, " we_count"}, 32'(m_we_n), (!exp_err && we) ? 32'd1 : 32'd0);
        check({tag, " wbv_count"}, 32'(m_wbv_n), (!exp_err && !we) ? 32'd1 : 32'd0);
        if (!exp_err && !(we && size == 2'd2)) begin
            check({tag, " nd_cycle"}, 32'(m_nd_c), 32'd1);
            check({tag, " nd_addr"},  32'(m_nd_addr), 32'(widx));
        end
        if (!exp_err && we) begin
            check({tag, " we_cycle"}, 32'(m_we_c), (size == 2'd2) ? 32'd1 : 32'(3 + d));
            check({tag, " we_addr"},  32'(m_we_addr), 32'(widx));
            check({tag, " mem_din"},  m_we_din, exp_val);
            ref_mem[widx] = exp_val;
        end
        if (!exp_err && !we) begin
            check({tag, " wbv_cycle"}, 32'(m_wbv_c), 32'(3 + d));
            check({tag, " wb_data"},   m_wb_data, exp_val);
            check({tag, " wb_rd"},     32'(m_wb_rd), 32'(rd));
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " busy"},     32'(busy),     32'd0);
        check({tag, " wb_valid"}, 32'(wb_valid), 32'd0);
        check({tag, " wb_data"},  wb_data,       32'd0);
        check({tag, " wb_rd"},    32'(wb_rd),    32'd0);
        check({tag, " done"},     32'(done),     32'd0);
        check({tag, " err"},      32'(err),      32'd0);
        check({tag, " mem_nd"},   32'(mem_nd),   32'd0);
        check({tag, " mem_we"},   32'(mem_we),   32'd0);
        check({tag, " mem_addr"}, 32'(mem_addr), 32'd0);
        check({tag, " mem_din"},  mem_din,       32'd0);
    endtask

    typedef struct packed {
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  rd;
        logic        exp_err;
        logic [31:0] exp_val;
    } vec_t;

    function automatic vec_t mk(input logic we, input logic [1:0] size, input logic sgn,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [4:0] rd, input logic exp_err, input logic [31:0] exp_val);
        vec_t v;
        v.we = we; v.size = size; v.sgn = sgn; v.addr = addr; v.wdata = wdata;
        v.rd = rd; v.exp_err = exp_err; v.exp_val = exp_val;
        return v;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t        vecs [17];
        logic        r_we, r_sgn, r_err;
        logic [1:0]  r_size;
        logic [31:0] r_addr, r_val;
        int          sel;

        vecs[0]  = mk(1, 2'd2, 0, 32'h14, 32'hDEAD_BEEF, 5'd0, 0, 32'hDEAD_BEEF);
        vecs[1]  = mk(0, 2'd2, 0, 32'h14, 32'h0,         5'd3, 0, 32'hDEAD_BEEF);
        vecs[2]  = mk(1, 2'd2, 0, 32'h14, 32'h80F1_7F00, 5'd0, 0, 32'h80F1_7F00);
        vecs[3]  = mk(0, 2'd0, 1, 32'h17, 32'h0,         5'd4, 0, 32'hFFFF_FF80);
        vecs[4]  = mk(0, 2'd0, 0, 32'h17, 32'h0,         5'd5, 0, 32'h0000_0080);
        vecs[5]  = mk(0, 2'd1, 1, 32'h16, 32'h0,         5'd6, 0, 32'hFFFF_80F1);
        vecs[6]  = mk(0, 2'd1, 0, 32'h14, 32'h0,         5'd7, 0, 32'h0000_7F00);
        vecs[7]  = mk(0, 2'd0, 1, 32'h15, 32'h0,         5'd8, 0, 32'h0000_007F);
        vecs[8]  = mk(1, 2'd2, 0, 32'h08, 32'h1122_3344, 5'd0, 0, 32'h1122_3344);
        vecs[9]  = mk(1, 2'd0, 0, 32'h09, 32'hFFFF_FFAA, 5'd0, 0, 32'h1122_AA44);
        vecs[10] = mk(0, 2'd2, 0, 32'h08, 32'h0,         5'd9, 0, 32'h1122_AA44);
        vecs[11] = mk(1, 2'd1, 0, 32'h0A, 32'h1234_BEEF, 5'd0, 0, 32'hBEEF_AA44);
        vecs[12] = mk(0, 2'd1, 1, 32'h0A, 32'h0,         5'd31, 0, 32'hFFFF_BEEF);
        vecs[13] = mk(0, 2'd1, 0, 32'h03, 32'h0,         5'd1, 1, 32'h0);
        vecs[14] = mk(0, 2'd3, 0, 32'h10, 32'h0,         5'd1, 1, 32'h0);
        vecs[15] = mk(0, 2'd2, 0, 32'h2000, 32'h0,       5'd1, 1, 32'h0);
        vecs[16] = mk(1, 2'd2, 0, 32'h06, 32'h1234_5678, 5'd0, 1, 32'h0);

        for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_pat(i);

        rst_n = 1'b0; ram_init = 1'b1; rdy_block = 1'b0; ram_delay = 0;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_signed = 1'b0;
        req_addr = 32'd0; req_wdata = 32'd0; req_rd = 5'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1; ram_init = 1'b0;

        // ---- directed table ----
        for (int i = 0; i < 17; i++) begin
            run_txn($sformatf("vec%0d", i), vecs[i].we, vecs[i].size, vecs[i].sgn,
                    vecs[i].addr, vecs[i].wdata, vecs[i].rd, vecs[i].exp_err, vecs[i].exp_val);
        end

        // ---- timeout: RAM never answers ----
        rdy_block = 1'b1;
        issue(0, 2'd2, 0, 32'h20, 32'h0, 5'd7);
        monitor(40);
        check("timeout done_cycle", 32'(m_done_c), 32'(TIMEOUT + 2));
        check("timeout err_count",  32'(m_err_n),  32'd1);
        check("timeout busy_cycles", 32'(m_busy_n), 32'(TIMEOUT + 1));
        check("timeout nd_count",   32'(m_nd_n),   32'd1);
        check("timeout wbv_count",  32'(m_wbv_n),  32'd0);
        check("timeout we_count",   32'(m_we_n),   32'd0);
        rdy_block = 1'b0;

        // ---- reset during the read phase of a byte store ----
        ram_delay = 3;
        issue(1, 2'd0, 0, 32'h41, 32'h0000_0055, 5'd0);
        @(negedge clk);
        @(negedge clk);
        check("rmw busy_before_reset", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check_all_zero("rmw_reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        ram_delay = 0;
        monitor(8);
        check("rmw after_reset we_count",   32'(m_we_n),   32'd0);
        check("rmw after_reset busy_count", 32'(m_busy_n), 32'd0);
        check("rmw ram_unchanged", ram[16], ref_mem[16]);
        model(0, 2'd2, 0, 32'h40, 32'h0, r_err, r_val);
        run_txn("post_reset_load", 0, 2'd2, 0, 32'h40, 32'h0, 5'd12, r_err, r_val);

        // ---- randomized traffic against the reference model ----
        for (int n = 0; n < 150; n++) begin
            r_we   = 1'($urandom_range(0, 1));
            r_sgn  = 1'($urandom_range(0, 1));
            sel    = int'($urandom_range(0, 19));
            r_size = (sel == 0) ? 2'd3 : 2'(sel % 3);
            r_addr = {25'd0, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3))};
            if ($urandom_range(0, 15) == 0) begin
                r_addr = r_addr | (32'd1 << $urandom_range(ADDR_W + 2, 31));
            end else if ($urandom_range(0, 3) != 0) begin
                if (r_size == 2'd1) r_addr[0] = 1'b0;
                if (r_size == 2'd2) r_addr[1:0] = 2'b00;
            end
            ram_delay = int'($urandom_range(0, 4));
            model(r_we, r_size, r_sgn, r_addr, 32'($urandom), r_err, r_val);
            // Re-derive with the exact store data that is actually issued.
            req_wdata = 32'($urandom);
            model(r_we, r_size, r_sgn, r_addr, req_wdata, r_err, r_val);
            run_txn($sformatf("rnd%0d", n), r_we, r_size, r_sgn, r_addr, req_wdata,
                    5'($urandom_range(0, 31)), r_err, r_val);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Load/store controller sitting directly upstream of the MEM_WB data RAM.
- Accepts one byte-addressed load/store per transaction from the EX/MEM pipeline register.
- Drives the RAM's word-addressed nd/we/addr/din interface and waits on its rdy flag.
- Performs sub-word extraction/sign-extension for loads and read-modify-write for byte/halfword stores; produces writeback data plus a stall signal for the core.

Parameters:
ADDR_W, 11, RAM word-address width (RAM depth 2^ADDR_W words)
TIMEOUT, 15, max cycles in WAIT for mem_rdy before aborting with error (1..255)

Ports:
clk  in  1  core clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present (sampled only in IDLE)
req_we  in  1  1=store, 0=load
req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal
req_signed  in  1  sign-extend sub-word loads
req_addr  in  32  byte address
req_wdata  in  32  store data, right-justified
req_rd  in  5  destination register tag for loads
busy  out  1  stall; combinational, high whenever state != IDLE
wb_valid  out  1  one-cycle pulse, load data valid
wb_data  out  32  extracted/extended load data
wb_rd  out  5  tag of completed load
done  out  1  one-cycle pulse on any completed transaction (load, store, or error)
err  out  1  one-cycle pulse: misaligned, illegal size, out-of-range, or timeout
mem_addr  out  ADDR_W  RAM word address = latched addr[ADDR_W+1:2]
mem_din  out  32  RAM write data
mem_dout  in  32  RAM read data (high-Z when not reading)
mem_nd  out  1  RAM read request
mem_rdy  in  1  RAM read-ready (registered in RAM, valid the cycle after nd is sampled)
mem_we  out  1  RAM write enable

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0 (busy, wb_valid, wb_data, wb_rd, done, err, mem_nd, mem_we, mem_addr, mem_din); latched request and timeout counter cleared. Reset mid-transaction aborts it; no partial write is issued after reset.
- States: IDLE, RD, WAIT, WR, RESP.
- IDLE:
  - On req_valid, latch all req_* fields.
  - Check in order: size==11, misaligned (half: addr[0]!=0; word: addr[1:0]!=0), out-of-range (addr[31:ADDR_W+2]!=0).
  - Any failure: err=1 and done=1 next cycle, no RAM access, stay IDLE.
  - Else load or sub-word store -> RD; word store -> WR.
- RD: mem_nd=1 for exactly one cycle -> WAIT; counter cleared.
- WAIT:
  - mem_nd=0. Each cycle with mem_rdy=1, capture mem_dout.
    - Load -> RESP.
    - Store -> merge data into the captured word -> WR.
  - mem_rdy=0: increment counter; counter==TIMEOUT -> err=1, done=1, IDLE.
- WR: mem_we=1 and mem_din=merged or full word for exactly one cycle; done=1 next cycle -> IDLE.
- RESP: wb_valid=1, done=1, wb_data and wb_rd stable -> IDLE.
- Lanes are little-endian: byte lane b = addr[1:0] occupies bits 8b+7:8b; halfword lane occupies 16*addr[1]+15:16*addr[1].
- Load extraction: selected lane right-justified; upper bits = lane MSB if req_signed, else 0.
- Store merge: only the selected lane is replaced by req_wdata low bits; other bytes come from the RAM read.
- Latency, with request sampled at edge E0:
  - Load: wb_valid high in cycle 3 (RD cycle 1, WAIT cycle 2 with rdy, RESP cycle 3).
  - Word store: mem_we in cycle 1.
  - Sub-word store: mem_we in cycle 3.
- req_valid while busy is ignored and not queued; the core holds it stalled.
- mem_addr and mem_din hold their last values between transactions.
- wb_data holds until the next load completes.

Decomposition:
- Package musa_mem_pkg: size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), state enum, lane-select helper functions.
- One combinational sub-module, mem_lane_align: inputs word, byte offset, size, signed, wdata; outputs extracted load data and merged store word.
- The FSM and timeout counter stay in mem_access_ctrl.

Test Plan:
- Word load: RAM[5]=0xDEADBEEF, load word addr 0x14, rd=3 -> mem_nd pulse cycle 1, wb_valid cycle 3, wb_data=0xDEADBEEF, wb_rd=3, busy high cycles 1-3.
- Signed/unsigned byte load: RAM[5]=0x80F17F00.
  - Signed byte addr 0x17 -> 0xFFFFFF80.
  - Unsigned byte addr 0x17 -> 0x00000080.
  - Signed half addr 0x16 -> 0xFFFF80F1.
- Byte store RMW: RAM[2]=0x11223344, store byte 0xAA at addr 0x09 -> single mem_we in cycle 3 with mem_din=0x1122AA44; word load of addr 0x08 then returns 0x1122AA44.
- Errors:
  - Half load at addr 0x03 -> err and done pulse next cycle, mem_nd/mem_we never asserted.
  - Same result for size=11.
  - Same result for addr 0x00002000 with ADDR_W=11.
- Timeout: tie mem_rdy=0, issue load -> err pulse exactly TIMEOUT cycles after entering WAIT, busy then drops, no wb_valid.
- Reset mid-RMW: drop rst_n during WAIT of a byte store -> all outputs 0 immediately, no mem_we afterwards, RAM word unchanged; next request proceeds normally.
